// File: rtl/ktane_wire_pkg.sv
// Shared definitions for the wire sense scanner and the wire memory read decoder.
package ktane_wire_pkg;

  localparam int unsigned NUM_CH     = 6;
  localparam int unsigned VAL_WIDTH  = 7;
  localparam int unsigned CUT_THRESH = 10;
  localparam int unsigned CH_W       = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_NEXT   = 3'd4
  } scan_state_e;

  // Bit offset of a channel's slot inside the packed wire_val vector.
  function automatic int unsigned slot_off(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/wire_scan_ctrl_if.sv
// ADC reader handshake: channel select and start from the sequencer, done and result back.
interface wire_scan_ctrl_if #(
  parameter int unsigned VW = ktane_wire_pkg::VAL_WIDTH
) ();

  logic [ktane_wire_pkg::CH_W-1:0] adc_pin;
  logic                            adc_start;
  logic                            adc_done;
  logic [VW-1:0]                   adc_val;

  modport master (
    output adc_pin,
    output adc_start,
    input  adc_done,
    input  adc_val
  );

  modport slave (
    input  adc_pin,
    input  adc_start,
    output adc_done,
    output adc_val
  );

endinterface

// File: rtl/wire_cut_det.sv
// Per-wire cut detector: saturating count of consecutive low samples and a sticky cut flag.
module wire_cut_det #(
  parameter int unsigned VAL_WIDTH  = ktane_wire_pkg::VAL_WIDTH,
  parameter int unsigned CUT_THRESH = ktane_wire_pkg::CUT_THRESH,
  parameter int unsigned CUT_COUNT  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_en,
  input  logic [VAL_WIDTH-1:0] sample_val,
  output logic                 cut
);

  localparam int unsigned LC_W = $clog2(CUT_COUNT + 1);

  logic [LC_W-1:0] low_q;
  logic [LC_W-1:0] low_d;
  logic            cut_q;
  logic            low_c;

  assign low_c = (sample_val < VAL_WIDTH'(CUT_THRESH));

  // Once cut, a healthy reading no longer clears the count; the flag is sticky anyway.
  always_comb begin
    low_d = low_q;
    if (sample_en) begin
      if (low_c) begin
        if (low_q != LC_W'(CUT_COUNT)) low_d = low_q + LC_W'(1);
      end else if (!cut_q) begin
        low_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_q <= '0;
      cut_q <= 1'b0;
    end else begin
      low_q <= low_d;
      cut_q <= cut_q | (low_d == LC_W'(CUT_COUNT));
    end
  end

  assign cut = cut_q;

endmodule

// File: rtl/wire_scan_ctrl.sv
// Round-robin wire sense sequencer: settle/start/wait handshake per channel, result
// storage, cut detection and conversion timeout flag.
module wire_scan_ctrl #(
  parameter int unsigned NUM_CH         = ktane_wire_pkg::NUM_CH,
  parameter int unsigned VAL_WIDTH      = ktane_wire_pkg::VAL_WIDTH,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CUT_THRESH     = ktane_wire_pkg::CUT_THRESH,
  parameter int unsigned CUT_COUNT      = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  wire_scan_ctrl_if.master            adc,
  output logic [NUM_CH*VAL_WIDTH-1:0] wire_val,
  output logic [NUM_CH-1:0]           val_valid,
  output logic [NUM_CH-1:0]           wire_cut,
  output logic                        scan_done,
  output logic                        timeout_err,
  input  logic                        err_clr
);

  import ktane_wire_pkg::*;

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES
                                                                     : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  scan_state_e     state_q;
  logic [CH_W-1:0] ch_q;
  logic [CNT_W-1:0] cnt_q;
  logic            timeout_q;

  logic [VAL_WIDTH-1:0] val_q [NUM_CH];
  logic [NUM_CH-1:0]    valid_q;

  logic done_acc_c;
  logic to_hit_c;

  assign done_acc_c = (state_q == S_WAIT) && adc.adc_done;
  assign to_hit_c   = (state_q == S_WAIT) && !adc.adc_done
                      && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Sequencer; cnt_q is shared between settle timing and the conversion watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ch_q      <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (to_hit_c)     timeout_q <= 1'b1;
      else if (err_clr) timeout_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (en) state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt_q   <= '0;
            state_q <= S_START;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_START: begin
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (done_acc_c || to_hit_c) state_q <= S_NEXT;
          else                        cnt_q   <= cnt_q + CNT_W'(1);
        end
        S_NEXT: begin
          cnt_q   <= '0;
          ch_q    <= (ch_q == LAST_CH) ? '0 : ch_q + CH_W'(1);
          state_q <= en ? S_SETTLE : S_IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Latest reading per channel, written only by a done accepted in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) val_q[i] <= '0;
      valid_q <= '0;
    end else if (done_acc_c) begin
      val_q[ch_q]   <= adc.adc_val;
      valid_q[ch_q] <= 1'b1;
    end
  end

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    logic sample_en_c;

    assign sample_en_c = done_acc_c && (ch_q == CH_W'(i));

    wire_cut_det #(
      .VAL_WIDTH  (VAL_WIDTH),
      .CUT_THRESH (CUT_THRESH),
      .CUT_COUNT  (CUT_COUNT)
    ) u_cut_det (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_en  (sample_en_c),
      .sample_val (adc.adc_val),
      .cut        (wire_cut[i])
    );

    assign wire_val[slot_off(i, VAL_WIDTH) +: VAL_WIDTH] = val_q[i];
  end

  assign adc.adc_pin   = ch_q;
  assign adc.adc_start = (state_q == S_START);
  assign scan_done     = (state_q == S_NEXT) && (ch_q == LAST_CH);
  assign timeout_err   = timeout_q;
  assign val_valid     = valid_q;

endmodule

// File: tb/tb_wire_scan_ctrl.sv
// Bench for wire_scan_ctrl: ADC responder driven per channel, stored results checked against a queue.
module tb_wire_scan_ctrl;

  localparam int NCH = 6;
  localparam int VW  = 7;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic en      = 1'b0;
  logic err_clr = 1'b0;

  logic [NCH*VW-1:0] wire_val;
  logic [NCH-1:0]    val_valid;
  logic [NCH-1:0]    wire_cut;
  logic              scan_done;
  logic              timeout_err;

  wire_scan_ctrl_if adc_if ();

  wire_scan_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .adc         (adc_if),
    .wire_val    (wire_val),
    .val_valid   (val_valid),
    .wire_cut    (wire_cut),
    .scan_done   (scan_done),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    pin;
    logic [VW-1:0] val;
  } exp_t;

  exp_t          sb_q[$];
  logic [VW-1:0] m_val [NCH];
  logic [NCH-1:0] m_valid;
  logic [NCH-1:0] m_cut;
  int            m_low [NCH];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_val[i] = '0;
      m_low[i] = 0;
    end
    m_valid = '0;
    m_cut   = '0;
  endtask

  function automatic logic [NCH*VW-1:0] m_vec();
    logic [NCH*VW-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*VW +: VW] = m_val[i];
    return v;
  endfunction

  // Reading returned for a channel on a given scan pass.
  function automatic int val_for(input int scan, input int ch);
    int l4 [5];
    l4 = '{3, 3, 50, 3, 3};
    if (ch == 2 && scan >= 1 && scan <= 3) return 3;
    if (ch == 2 && scan == 4)              return 90;
    if (ch == 4 && scan >= 1 && scan <= 5) return l4[scan-1];
    return 20 + ch;
  endfunction

  task automatic check_store();
    exp_t e;
    int   p;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 64'(1), 64'(0));
      return;
    end
    e = sb_q.pop_front();
    p = int'(e.pin);
    m_val[p]   = e.val;
    m_valid[p] = 1'b1;
    if (int'(e.val) < 10) begin
      if (m_low[p] < 3) m_low[p]++;
    end else if (!m_cut[p]) begin
      m_low[p] = 0;
    end
    if (m_low[p] == 3) m_cut[p] = 1'b1;
    chk("wire_val", 64'(wire_val), 64'(m_vec()));
    chk("val_valid", 64'(val_valid), 64'(m_valid));
    chk("wire_cut", 64'(wire_cut), 64'(m_cut));
  endtask

  task automatic wait_start(input int pin, input bit gap);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!adc_if.adc_start && n < 2000);
    chk("start_seen", 64'(adc_if.adc_start), 64'(1));
    chk("adc_pin", 64'(adc_if.adc_pin), 64'(pin));
    if (gap) chk("settle_gap", 64'(n), 64'(17));
  endtask

  task automatic finish(input int pin, input int val, input int dly);
    exp_t e;
    if (dly > 0) begin
      @(negedge clk);
      chk("start_pulse", 64'(adc_if.adc_start), 64'(0));
      repeat (dly - 1) @(negedge clk);
    end
    adc_if.adc_done = 1'b1;
    adc_if.adc_val  = VW'(val);
    e.pin = 3'(pin);
    e.val = VW'(val);
    sb_q.push_back(e);
    @(negedge clk);
    adc_if.adc_done = 1'b0;
    check_store();
    chk("scan_done", 64'(scan_done), 64'(pin == NCH - 1));
  endtask

  task automatic serve(input int pin, input int val, input int dly, input bit gap);
    wait_start(pin, gap);
    finish(pin, val, dly);
  endtask

  initial begin
    int starts;
    model_reset();
    adc_if.adc_done = 1'b0;
    adc_if.adc_val  = '0;

    #12;
    chk("rst_pin", 64'(adc_if.adc_pin), 64'(0));
    chk("rst_start", 64'(adc_if.adc_start), 64'(0));
    chk("rst_wire_val", 64'(wire_val), 64'(0));
    chk("rst_valid", 64'(val_valid), 64'(0));
    chk("rst_cut", 64'(wire_cut), 64'(0));
    chk("rst_scan_done", 64'(scan_done), 64'(0));
    chk("rst_timeout", 64'(timeout_err), 64'(0));

    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) en = 1'b1;

    // Basic scan, then cut and non-consecutive-low passes with varied done latency
    for (int ch = 0; ch < NCH; ch++) serve(ch, val_for(0, ch), 5, ch != 0);
    chk("valid_all", 64'(val_valid), 64'(6'h3f));
    for (int s = 1; s <= 5; s++) begin
      for (int ch = 0; ch < NCH; ch++)
        serve(ch, val_for(s, ch), (s == 1) ? 1 + ch : 5, 1'b1);
      if (s == 3) chk("cut2_set", 64'(wire_cut[2]), 64'(1));
    end
    chk("cut2_sticky", 64'(wire_cut[2]), 64'(1));
    chk("cut4_clear", 64'(wire_cut[4]), 64'(0));

    // Timeout on channel 1, late done ignored, then cleared
    serve(0, 20, 5, 1'b1);
    wait_start(1, 1'b1);
    repeat (1024) @(negedge clk);
    chk("to_not_yet", 64'(timeout_err), 64'(0));
    @(negedge clk);
    chk("to_set", 64'(timeout_err), 64'(1));
    chk("to_pin", 64'(adc_if.adc_pin), 64'(1));
    chk("to_slot", 64'(wire_val), 64'(m_vec()));
    chk("to_valid", 64'(val_valid), 64'(m_valid));
    @(negedge clk);
    chk("to_next_pin", 64'(adc_if.adc_pin), 64'(2));
    adc_if.adc_done = 1'b1;
    adc_if.adc_val  = VW'(99);
    @(negedge clk);
    adc_if.adc_done = 1'b0;
    chk("late_done", 64'(wire_val), 64'(m_vec()));
    serve(2, 22, 5, 1'b0);
    for (int ch = 3; ch < NCH; ch++) serve(ch, 20 + ch, 5, 1'b1);
    chk("to_held", 64'(timeout_err), 64'(1));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("to_clr", 64'(timeout_err), 64'(0));

    // Enable dropped during WAIT on channel 3
    serve(0, 30, 3, 1'b0);
    serve(1, 31, 2, 1'b1);
    serve(2, 32, 4, 1'b1);
    wait_start(3, 1'b1);
    @(negedge clk);
    en = 1'b0;
    finish(3, 33, 4);
    starts = 0;
    repeat (8) begin
      @(negedge clk);
      if (adc_if.adc_start) starts++;
    end
    chk("idle_no_start", 64'(starts), 64'(0));
    chk("idle_pin", 64'(adc_if.adc_pin), 64'(4));
    en = 1'b1;
    serve(4, 44, 5, 1'b1);
    serve(5, 45, 5, 1'b1);

    // Async reset mid-SETTLE of channel 1
    serve(0, 40, 5, 1'b1);
    repeat (5) @(negedge clk);
    chk("pre_rst_pin", 64'(adc_if.adc_pin), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pin", 64'(adc_if.adc_pin), 64'(0));
    chk("arst_wire_val", 64'(wire_val), 64'(0));
    chk("arst_valid", 64'(val_valid), 64'(0));
    chk("arst_cut", 64'(wire_cut), 64'(0));
    chk("arst_timeout", 64'(timeout_err), 64'(0));
    model_reset();
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    adc_if.adc_done = 1'b1;
    adc_if.adc_val  = VW'(77);
    @(negedge clk);
    adc_if.adc_done = 1'b0;
    chk("stale_done", 64'(val_valid), 64'(0));
    serve(0, 20, 5, 1'b0);
    serve(1, 21, 5, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wire_scan_ctrl.md
# wire_scan_ctrl

Scan sequencer for the six bomb-module wire sense channels. Steps round-robin through ADC pins 0–5 with a settle → start → wait-for-done handshake to the ADC reader, and holds the latest 7-bit reading per wire for the memory-mapped wire read port. Also flags wires as cut after consecutive low readings, and flags stalled conversions with a timeout.

## Interface
Parameters:
- NUM_CH, 6: number of wire channels scanned; channel index 0..NUM_CH-1 maps to adc_pin.
- VAL_WIDTH, 7: ADC reading width.
- SETTLE_CYCLES, 16: cycles adc_pin is held before adc_start; must be ≥1.
- TIMEOUT_CYCLES, 1024: maximum WAIT cycles before a conversion is abandoned.
- CUT_THRESH, 10: a reading strictly below this counts as a low sample.
- CUT_COUNT, 3: consecutive low samples needed to declare a wire cut.

Ports:
- clk, in, 1: sole clock; all state on posedge.
- rst_n, in, 1: asynchronous, active-low reset.
- en, in, 1: scan enable.
- adc_pin, out, 3: channel select to the ADC reader.
- adc_start, out, 1: one-cycle conversion start pulse.
- adc_done, in, 1: one-cycle conversion complete pulse.
- adc_val, in, VAL_WIDTH: conversion result; valid only with adc_done.
- wire_val, out, NUM_CH*VAL_WIDTH: latest reading per channel; channel i occupies bits [i*VAL_WIDTH +: VAL_WIDTH].
- val_valid, out, NUM_CH: channel has at least one stored reading.
- wire_cut, out, NUM_CH: sticky cut flag per channel.
- scan_done, out, 1: one-cycle pulse when channel NUM_CH-1 completes.
- timeout_err, out, 1: sticky conversion timeout flag.
- err_clr, in, 1: clears timeout_err.

## Operation
- States: IDLE, SETTLE, START, WAIT, NEXT.
- IDLE:
  - Go to SETTLE when en=1.
  - The channel index is retained, so a resumed scan continues where it stopped.
- SETTLE:
  - Drive adc_pin=ch.
  - Count SETTLE_CYCLES cycles, then go to START.
- START:
  - adc_start=1 for exactly this cycle.
  - Always go to WAIT.
- WAIT:
  - On adc_done=1: write adc_val into slot ch, set val_valid[ch], update the cut counter, go to NEXT.
  - If the wait counter reaches TIMEOUT_CYCLES-1 without done: set timeout_err, leave the slot and counter unchanged, go to NEXT.
- NEXT:
  - ch ← ch+1, wrapping from NUM_CH-1 to 0.
  - scan_done=1 on the wrap.
  - Go to SETTLE if en=1, else IDLE.
- en is sampled only in IDLE and NEXT. Deasserting en mid-channel lets the current conversion finish.
- adc_done outside WAIT is ignored, including a late done after a timeout.
- Cut detection, per channel, saturating counter 0..CUT_COUNT:
  - Low sample: increment.
  - Sample ≥ CUT_THRESH: clear to 0, only while not cut.
  - wire_cut[i] sets when the counter reaches CUT_COUNT.
  - wire_cut is cleared only by reset; a cut wire stays cut.
- timeout_err:
  - err_clr clears it.
  - If a set and a clear occur in the same cycle, the set wins.

## Timing
- Reset values:
  - State IDLE, ch=0, adc_pin=0, adc_start=0.
  - wire_val all 0, val_valid=0, wire_cut=0, cut counters 0.
  - scan_done=0, timeout_err=0.
- Outputs are registered. adc_pin, adc_start and scan_done are decoded from registered state and ch, with no combinational path from any input.
- adc_pin changes only on the NEXT→SETTLE/IDLE edge and is stable from SETTLE through WAIT.
- Result latency: for adc_done sampled in WAIT on cycle t, wire_val, val_valid and wire_cut reflect it from cycle t+1.
- Per-channel period: SETTLE_CYCLES + 1 (START) + N (cycles to done, N≥1) + 1 (NEXT).
- adc_done in the first WAIT cycle, the cycle after adc_start, is accepted.
- Reset asserted mid-conversion returns everything to reset values immediately. A pending adc_done after reset is ignored until a new WAIT.

## Structure
- Shared package ktane_wire_pkg holds:
  - State encoding constants.
  - NUM_CH, VAL_WIDTH and CUT_THRESH defaults.
  - The wire_val slot offset macro/function, shared with the wire memory read decoder.
- One sub-module, wire_cut_det, instantiated NUM_CH times. It contains the saturating low-sample counter and the sticky cut flag, with inputs sample_en, sample_val, clk, rst_n.

## Test plan
- Basic scan: reset, en=1, ADC model returns 20+ch with done 5 cycles after start → six adc_start pulses on pins 0..5 in order, each after 16 settle cycles; wire_val slots = 20..25; val_valid=6'b111111; one scan_done on the ch 5 completion.
- Cut detect: channel 2 returns 3 on three consecutive scans → wire_cut[2] rises the cycle after the 3rd done; a later reading of 90 leaves it set.
- Non-consecutive low: channel 4 returns 3, 3, 50, 3, 3 → wire_cut[4] stays 0.
- Timeout: channel 1 never gives done → timeout_err=1 after 1024 WAIT cycles, slot 1 unchanged, scan proceeds to pin 2; a late done is ignored; err_clr → 0.
- Enable drop: deassert en during WAIT on ch 3 → conversion completes and is stored, state goes to IDLE with adc_pin=4; re-enable → next start is on pin 4.
- Async reset: assert rst_n=0 mid-SETTLE with no clock edge → all outputs take reset values immediately; after release the scan restarts at pin 0.
